// File: rtl/pe_post_pkg.sv
// Shared types and constants for the PE post-activation stage.
package pe_post_pkg;

  localparam int unsigned ACC_W       = 24;
  localparam int unsigned BIAS_W      = 24;
  localparam int unsigned OUT_W       = 8;
  localparam int unsigned SHIFT_W     = 5;
  localparam int unsigned LEAKY_SHIFT = 3;
  localparam int unsigned SUM_W       = 26;
  localparam int unsigned RND_W       = 27;
  localparam int unsigned SHIFT_MAX   = 24;
  localparam int          OUT_MAX     = 127;
  localparam int          OUT_MIN     = -128;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BIAS,
    S_ACT,
    S_QUANT
  } state_e;

  function automatic logic [SHIFT_W-1:0] clamp_shift(input logic [SHIFT_W-1:0] s);
    return (s > SHIFT_W'(SHIFT_MAX)) ? SHIFT_W'(SHIFT_MAX) : s;
  endfunction

endpackage

// File: rtl/post_out_fifo2.sv
// Two-entry synchronous FIFO; head register reads as zero when empty.
module post_out_fifo2 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  logic [1:0]   cnt;
  logic [W-1:0] head_q;
  logic [W-1:0] tail_q;
  logic         pop_ok_c;
  logic         push_ok_c;

  always_comb begin
    pop_ok_c  = pop && (cnt != 2'd0);
    push_ok_c = push && ((cnt != 2'd2) || pop_ok_c);
  end

  // Shift-register organisation keeps the head in a fixed register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt    <= 2'd0;
      head_q <= '0;
      tail_q <= '0;
    end else if (pop_ok_c && push_ok_c) begin
      if (cnt == 2'd1) begin
        head_q <= din;
      end else begin
        head_q <= tail_q;
        tail_q <= din;
      end
    end else if (pop_ok_c) begin
      head_q <= (cnt == 2'd2) ? tail_q : '0;
      tail_q <= '0;
      cnt    <= cnt - 2'd1;
    end else if (push_ok_c) begin
      if (cnt == 2'd0) head_q <= din;
      else             tail_q <= din;
      cnt <= cnt + 2'd1;
    end
  end

  assign dout  = head_q;
  assign full  = (cnt == 2'd2);
  assign empty = (cnt == 2'd0);

endmodule

// File: rtl/pe_post_act.sv
// Bias add, leaky ReLU and int8 requantization of MAC results, with a
// 2-entry output queue behind a valid/ready handshake.
module pe_post_act
  import pe_post_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [ACC_W-1:0]     mac_in,
  input  logic [BIAS_W-1:0]    bias_in,
  input  logic [SHIFT_W-1:0]   shift_in,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_W-1:0]     out_data,
  output logic                 sat_flag,
  input  logic                 clr_flag
);

  localparam logic signed [RND_W-1:0] R_MAX = RND_W'(OUT_MAX);
  localparam logic signed [RND_W-1:0] R_MIN = RND_W'(OUT_MIN);

  state_e                    state;
  logic [ACC_W-1:0]          mac_q;
  logic [BIAS_W-1:0]         bias_q;
  logic [SHIFT_W-1:0]        shift_q;
  logic signed [SUM_W-1:0]   sum_q;
  logic signed [SUM_W-1:0]   act_q;

  logic signed [RND_W-1:0]   act_ext_c;
  logic signed [RND_W-1:0]   half_c;
  logic signed [RND_W-1:0]   r_c;
  logic [OUT_W-1:0]          q_c;
  logic                      clip_c;
  logic                      push_c;
  logic                      pop_c;
  logic                      fifo_full;
  logic                      fifo_empty;

  // Round-half-up right shift and saturation of the activated value
  always_comb begin
    act_ext_c = {act_q[SUM_W-1], act_q};
    half_c    = '0;
    if (shift_q != '0) half_c = RND_W'(1) << (shift_q - SHIFT_W'(1));
    r_c       = (shift_q == '0) ? act_ext_c : ((act_ext_c + half_c) >>> shift_q);
    clip_c    = 1'b0;
    q_c       = OUT_W'(r_c);
    if (r_c > R_MAX) begin
      q_c    = OUT_W'(OUT_MAX);
      clip_c = 1'b1;
    end else if (r_c < R_MIN) begin
      q_c    = OUT_W'(OUT_MIN);
      clip_c = 1'b1;
    end
  end

  assign pop_c  = !fifo_empty && out_ready;
  assign push_c = (state == S_QUANT) && (!fifo_full || pop_c);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      mac_q   <= '0;
      bias_q  <= '0;
      shift_q <= '0;
      sum_q   <= '0;
      act_q   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            mac_q   <= mac_in;
            bias_q  <= bias_in;
            shift_q <= clamp_shift(shift_in);
            state   <= S_BIAS;
          end
        end
        S_BIAS: begin
          sum_q <= $signed({2'b00, mac_q}) +
                   $signed({{(SUM_W-BIAS_W){bias_q[BIAS_W-1]}}, bias_q});
          state <= S_ACT;
        end
        S_ACT: begin
          act_q <= sum_q[SUM_W-1] ? (sum_q >>> LEAKY_SHIFT) : sum_q;
          state <= S_QUANT;
        end
        S_QUANT: begin
          if (push_c) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sticky clip indicator; a new clip beats a same-edge clear
  always_ff @(posedge clk) begin
    if (!rst_n)                  sat_flag <= 1'b0;
    else if (push_c && clip_c)   sat_flag <= 1'b1;
    else if (clr_flag)           sat_flag <= 1'b0;
  end

  assign in_ready  = (state == S_IDLE);
  assign out_valid = !fifo_empty;

  post_out_fifo2 #(.W(OUT_W)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_c),
    .pop   (pop_c),
    .din   (q_c),
    .dout  (out_data),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: doc/pe_post_act.md
Name: pe_post_act

Overview:
- Downstream neighbour of the 27-tap PE MAC.
- Takes one 24-bit unsigned accumulation per convolution window, adds a signed per-channel bias, applies leaky ReLU, then requantizes to a signed 8-bit activation with round-half-up and saturation.
- Results are buffered in a 2-entry output queue behind a valid/ready handshake, so the MAC can keep running while the feature-map writer stalls.

Parameters:
- ACC_W, 24, width of the incoming MAC result (unsigned).
- BIAS_W, 24, width of the bias (two's complement).
- LEAKY_SHIFT, 3, negative-slope divisor as a power of two (slope = 1/8).
- OUT_W, 8, width of the output activation (two's complement).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset; sampled on the rising edge of clk.
- in_valid  in  1  MAC result present; tied to the MAC done pulse.
- in_ready  out  1  block can accept a new result.
- mac_in  in  ACC_W  unsigned MAC accumulation.
- bias_in  in  BIAS_W  signed bias, sampled with mac_in.
- shift_in  in  5  requant right-shift, sampled with mac_in; values above 24 clamp to 24.
- out_valid  out  1  output queue non-empty.
- out_ready  in  1  consumer accepts out_data.
- out_data  out  OUT_W  head-of-queue activation.
- sat_flag  out  1  sticky: some result was clipped.
- clr_flag  in  1  clears sat_flag.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=S_IDLE, queue emptied, all pipeline registers cleared.
  - in_ready=1, out_valid=0, out_data=0, sat_flag=0.
  - Any in-flight result is discarded.
  - Reset mid-operation has no effect until the next edge, then the block is fully idle.
- in_ready equals (state==S_IDLE). A transfer occurs at an edge where in_valid && in_ready. in_valid while in_ready=0 is ignored; no buffering of dropped pulses, because the MAC cannot issue back-to-back results faster than the block's period.
- FSM:
  - S_IDLE: on transfer, capture mac_in, bias_in and the clamped shift, then go to S_BIAS.
  - S_BIAS: sum <= zero-extended mac + sign-extended bias, 26-bit signed; go to S_ACT.
  - S_ACT: act <= sum<0 ? (sum >>> LEAKY_SHIFT) : sum. Arithmetic shift, so negative values round toward minus infinity. Go to S_QUANT.
  - S_QUANT:
    - r = (shift==0) ? act : (act + (1<<(shift-1))) >>> shift, computed in 27 bits.
    - Saturate r to [-128, 127].
    - If the queue is not full, or a pop occurs this same edge, push and go to S_IDLE. Otherwise hold in S_QUANT with values frozen.
- Latency: accept edge E0, push at E3, out_valid=1 in the cycle after E3 (3 cycles, no stall). Throughput is one result per 4 cycles.
- Output queue:
  - 2-entry FIFO; out_data is the head entry, and it is 0 when the queue is empty.
  - Pop on out_valid && out_ready.
  - Push and pop on the same edge are legal in every state, including full; the count is unchanged.
  - Order is preserved.
- sat_flag:
  - Set on the push edge if clipping occurred.
  - clr_flag clears it.
  - If set and clear happen on the same edge, set wins.
- Width rules:
  - No intermediate overflow is possible: the 26-bit sum and 27-bit rounding bound all inputs.
  - Shift is applied after the activation, not before.

Decomposition:
- Shared package pe_post_pkg:
  - state enum (S_IDLE, S_BIAS, S_ACT, S_QUANT);
  - SUM_W=26 and RND_W=27;
  - OUT_MAX=127 and OUT_MIN=-128;
  - SHIFT_MAX=24.
- One sub-module: post_out_fifo2, a generic 2-deep synchronous FIFO with push/pop/full/empty, a width parameter and the same reset style.

Test Plan:
- mac=1000, bias=0, shift=3 -> out_data=125 (1004>>3), sat_flag=0; out_valid rises the 4th cycle after the accept edge.
- mac=100, bias=-420, shift=0 -> sum=-320, leaky -40 -> out_data=-40 (0xD8), sat_flag=0.
- mac=2000, bias=0, shift=2 -> 500 clips -> out_data=127, sat_flag=1. Then assert clr_flag together with a clipping result: sat_flag stays 1. clr_flag alone -> 0.
- mac=0, bias=-2000, shift=0 -> -250 -> out_data=-128; shift_in=31 with mac=0xFFFFFF, bias=0 -> clamp to 24 -> round(16777215/2^24)=1.
- Backpressure: out_ready=0, submit results 10, 20, 30 (shift 0) -> 10 and 20 queued, the third holds in S_QUANT with in_ready=0. Raise out_ready -> 10, 20, 30 delivered in order; simultaneous push/pop at full is observed.
- Assert rst_n=0 for one edge while in S_ACT with one queued entry -> next cycle out_valid=0, in_ready=1, sat_flag=0; the following result is processed normally.
